// File: rtl/cmd_arb_if.sv
// Command arbiter bus: two command sources in, one presented command out.
// master drives sources and the processor ack; slave is the arbiter.
interface cmd_arb_if;
    logic       rdy_a;
    logic [7:0] cmd_a;
    logic       clr_a;
    logic       rdy_b;
    logic [7:0] cmd_b;
    logic       clr_b;
    logic       cmd_rdy;
    logic [7:0] cmd;
    logic       clr_cmd_rdy;
    logic       src_b;
    logic       timeout;
    logic [7:0] drop_cnt;

    modport master (
        output rdy_a, cmd_a, rdy_b, cmd_b, clr_cmd_rdy,
        input  clr_a, clr_b, cmd_rdy, cmd, src_b, timeout, drop_cnt
    );

    modport slave (
        input  rdy_a, cmd_a, rdy_b, cmd_b, clr_cmd_rdy,
        output clr_a, clr_b, cmd_rdy, cmd, src_b, timeout, drop_cnt
    );
endinterface

// File: rtl/cmd_arb.sv
// Round-robin arbiter between two UART command sources, presenting one
// command at a time to the command processor with an ack timeout.
module cmd_arb #(
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter int unsigned CNT_W       = 11
) (
    input logic      clk,
    input logic      rst,
    cmd_arb_if.slave bus
);
    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q,    state_d;
    logic             cmd_rdy_q,  cmd_rdy_d;
    logic [7:0]       cmd_q,      cmd_d;
    logic             src_b_q,    src_b_d;
    logic             clr_a_q,    clr_a_d;
    logic             clr_b_q,    clr_b_d;
    logic             timeout_q,  timeout_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic             last_b_q,   last_b_d;

    logic grant_a;
    logic grant_b;

    // On contention the source not granted last wins; a lone request wins.
    always_comb begin
        grant_a = bus.rdy_a && (!bus.rdy_b || last_b_q);
        grant_b = bus.rdy_b && (!bus.rdy_a || !last_b_q);
    end

    // Next-state logic; clr_x and timeout default low so they pulse once.
    always_comb begin
        state_d    = state_q;
        cmd_rdy_d  = cmd_rdy_q;
        cmd_d      = cmd_q;
        src_b_d    = src_b_q;
        clr_a_d    = 1'b0;
        clr_b_d    = 1'b0;
        timeout_d  = 1'b0;
        drop_cnt_d = drop_cnt_q;
        cnt_d      = cnt_q;
        last_b_d   = last_b_q;
        case (state_q)
            IDLE: begin
                if (grant_a || grant_b) begin
                    state_d   = PRESENT;
                    cmd_rdy_d = 1'b1;
                    cmd_d     = grant_b ? bus.cmd_b : bus.cmd_a;
                    src_b_d   = grant_b;
                    clr_a_d   = grant_a;
                    clr_b_d   = grant_b;
                    last_b_d  = grant_b;
                    cnt_d     = '0;
                end
            end
            PRESENT: begin
                // An ack on the last allowed cycle still counts as an ack.
                if (bus.clr_cmd_rdy) begin
                    state_d   = IDLE;
                    cmd_rdy_d = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d    = IDLE;
                    cmd_rdy_d  = 1'b0;
                    timeout_d  = 1'b1;
                    drop_cnt_d = (drop_cnt_q == 8'hFF) ? drop_cnt_q
                                                       : drop_cnt_q + 8'd1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d   = IDLE;
                cmd_rdy_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset leaves B as last grant so A wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cmd_rdy_q  <= 1'b0;
            cmd_q      <= 8'h00;
            src_b_q    <= 1'b0;
            clr_a_q    <= 1'b0;
            clr_b_q    <= 1'b0;
            timeout_q  <= 1'b0;
            drop_cnt_q <= 8'h00;
            cnt_q      <= '0;
            last_b_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            cmd_rdy_q  <= cmd_rdy_d;
            cmd_q      <= cmd_d;
            src_b_q    <= src_b_d;
            clr_a_q    <= clr_a_d;
            clr_b_q    <= clr_b_d;
            timeout_q  <= timeout_d;
            drop_cnt_q <= drop_cnt_d;
            cnt_q      <= cnt_d;
            last_b_q   <= last_b_d;
        end
    end

    // Drive the bus straight from flops.
    always_comb begin
        bus.clr_a    = clr_a_q;
        bus.clr_b    = clr_b_q;
        bus.cmd_rdy  = cmd_rdy_q;
        bus.cmd      = cmd_q;
        bus.src_b    = src_b_q;
        bus.timeout  = timeout_q;
        bus.drop_cnt = drop_cnt_q;
    end
endmodule

// File: tb/tb_cmd_arb.sv
// Directed bench for cmd_arb with a 16-cycle timeout.
// Outputs are sampled 1 time unit after each rising edge.
module tb_cmd_arb;
    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    int   pulses;

    cmd_arb_if bus_if ();

    cmd_arb #(
        .TIMEOUT_CYC(16),
        .CNT_W      (5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    // 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        pulses      = 0;
        rst                = 1'b1;
        bus_if.rdy_a       = 1'b0;
        bus_if.cmd_a       = 8'h00;
        bus_if.rdy_b       = 1'b0;
        bus_if.cmd_b       = 8'h00;
        bus_if.clr_cmd_rdy = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_cmd_rdy", 32'(bus_if.cmd_rdy), 32'd0);
        check("rst_cmd", 32'(bus_if.cmd), 32'h00);
        check("rst_src_b", 32'(bus_if.src_b), 32'd0);
        check("rst_clr_a", 32'(bus_if.clr_a), 32'd0);
        check("rst_clr_b", 32'(bus_if.clr_b), 32'd0);
        check("rst_timeout", 32'(bus_if.timeout), 32'd0);
        check("rst_drop", 32'(bus_if.drop_cnt), 32'h00);
        rst = 1'b0;
        tick();
        check("idle_cmd_rdy", 32'(bus_if.cmd_rdy), 32'd0);

        // Single A command, acked after 3 presented cycles
        bus_if.rdy_a = 1'b1;
        bus_if.cmd_a = 8'h45;
        tick();
        check("a1_cmd_rdy", 32'(bus_if.cmd_rdy), 32'd1);
        check("a1_cmd", 32'(bus_if.cmd), 32'h45);
        check("a1_src_b", 32'(bus_if.src_b), 32'd0);
        check("a1_clr_a", 32'(bus_if.clr_a), 32'd1);
        check("a1_clr_b", 32'(bus_if.clr_b), 32'd0);
        bus_if.rdy_a = 1'b0;
        bus_if.cmd_a = 8'h11;
        tick();
        check("a2_cmd_rdy", 32'(bus_if.cmd_rdy), 32'd1);
        check("a2_clr_a", 32'(bus_if.clr_a), 32'd0);
        check("a2_cmd", 32'(bus_if.cmd), 32'h45);
        tick();
        check("a3_cmd_rdy", 32'(bus_if.cmd_rdy), 32'd1);
        check("a3_cmd", 32'(bus_if.cmd), 32'h45);
        bus_if.clr_cmd_rdy = 1'b1;
        tick();
        check("a4_cmd_rdy", 32'(bus_if.cmd_rdy), 32'd0);
        check("a4_cmd_hold", 32'(bus_if.cmd), 32'h45);
        check("a4_clr_a", 32'(bus_if.clr_a), 32'd0);
        tick();
        check("a5_idle_ack", 32'(bus_if.cmd_rdy), 32'd0);
        check("a5_timeout", 32'(bus_if.timeout), 32'd0);
        bus_if.clr_cmd_rdy = 1'b0;

        // Round robin from reset: A, B, A, B with immediate acks
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus_if.rdy_a       = 1'b1;
        bus_if.cmd_a       = 8'h41;
        bus_if.rdy_b       = 1'b1;
        bus_if.cmd_b       = 8'h82;
        bus_if.clr_cmd_rdy = 1'b1;
        tick();
        check("rr0_cmd", 32'(bus_if.cmd), 32'h41);
        check("rr0_src", 32'(bus_if.src_b), 32'd0);
        check("rr0_clr", {bus_if.clr_a, bus_if.clr_b}, 32'b10);
        tick();
        check("rr0_gap", 32'(bus_if.cmd_rdy), 32'd0);
        check("rr0_gclr", {bus_if.clr_a, bus_if.clr_b}, 32'b00);
        tick();
        check("rr1_cmd", 32'(bus_if.cmd), 32'h82);
        check("rr1_src", 32'(bus_if.src_b), 32'd1);
        check("rr1_clr", {bus_if.clr_a, bus_if.clr_b}, 32'b01);
        tick();
        check("rr1_gap", 32'(bus_if.cmd_rdy), 32'd0);
        tick();
        check("rr2_cmd", 32'(bus_if.cmd), 32'h41);
        check("rr2_clr", {bus_if.clr_a, bus_if.clr_b}, 32'b10);
        tick();
        check("rr2_gap", 32'(bus_if.cmd_rdy), 32'd0);
        tick();
        check("rr3_cmd", 32'(bus_if.cmd), 32'h82);
        check("rr3_rdy", 32'(bus_if.cmd_rdy), 32'd1);
        check("rr3_clr", {bus_if.clr_a, bus_if.clr_b}, 32'b01);
        bus_if.rdy_a = 1'b0;
        bus_if.rdy_b = 1'b0;
        tick();
        check("rr3_gap", 32'(bus_if.cmd_rdy), 32'd0);
        bus_if.clr_cmd_rdy = 1'b0;

        // B command never acked: 16 presented cycles then timeout
        bus_if.rdy_b = 1'b1;
        bus_if.cmd_b = 8'h7F;
        tick();
        check("to_cmd", 32'(bus_if.cmd), 32'h7F);
        check("to_src", 32'(bus_if.src_b), 32'd1);
        check("to_clr_b", 32'(bus_if.clr_b), 32'd1);
        bus_if.rdy_b = 1'b0;
        for (int i = 2; i <= 16; i++) begin
            tick();
            check("to_hold", {bus_if.cmd_rdy, bus_if.timeout}, 32'b10);
        end
        tick();
        check("to_end", {bus_if.cmd_rdy, bus_if.timeout}, 32'b01);
        check("to_drop", 32'(bus_if.drop_cnt), 32'd1);
        tick();
        check("to_once", 32'(bus_if.timeout), 32'd0);

        // Ack lands on the 16th cycle: acknowledged, not dropped
        bus_if.rdy_b = 1'b1;
        tick();
        check("ak_rdy", 32'(bus_if.cmd_rdy), 32'd1);
        bus_if.rdy_b = 1'b0;
        for (int i = 2; i <= 15; i++) tick();
        tick();
        check("ak_c16", 32'(bus_if.cmd_rdy), 32'd1);
        bus_if.clr_cmd_rdy = 1'b1;
        tick();
        check("ak_end", {bus_if.cmd_rdy, bus_if.timeout}, 32'b00);
        check("ak_drop", 32'(bus_if.drop_cnt), 32'd1);
        bus_if.clr_cmd_rdy = 1'b0;
        tick();
        check("ak_nopulse", 32'(bus_if.timeout), 32'd0);

        // Drive drop_cnt to 5, then reset mid-PRESENT
        bus_if.rdy_a = 1'b1;
        bus_if.cmd_a = 8'h5A;
        for (int i = 0; i < 200; i++) begin
            if (bus_if.drop_cnt == 8'd5) break;
            tick();
        end
        check("rs_drop5", 32'(bus_if.drop_cnt), 32'd5);
        tick();
        tick();
        check("rs_present", 32'(bus_if.cmd_rdy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rs_cmd_rdy", 32'(bus_if.cmd_rdy), 32'd0);
        check("rs_cmd", 32'(bus_if.cmd), 32'h00);
        check("rs_drop", 32'(bus_if.drop_cnt), 32'd0);
        bus_if.rdy_b = 1'b1;
        bus_if.cmd_a = 8'hA5;
        bus_if.cmd_b = 8'hB6;
        tick();
        check("rs_hold_clr", {bus_if.clr_a, bus_if.clr_b}, 32'b00);
        rst = 1'b0;
        check("rs_rel_clr", {bus_if.clr_a, bus_if.clr_b}, 32'b00);
        tick();
        check("rs_first_a", 32'(bus_if.cmd), 32'hA5);
        check("rs_first_src", 32'(bus_if.src_b), 32'd0);
        check("rs_first_clr", {bus_if.clr_a, bus_if.clr_b}, 32'b10);
        bus_if.rdy_b = 1'b0;

        // 300 back-to-back timeouts from A: drop_cnt saturates
        for (int i = 0; i < 6000 && pulses < 300; i++) begin
            tick();
            if (bus_if.timeout) begin
                pulses++;
                if (pulses == 254)
                    check("sat_254", 32'(bus_if.drop_cnt), 32'hFE);
                if (pulses == 255)
                    check("sat_255", 32'(bus_if.drop_cnt), 32'hFF);
            end
        end
        check("sat_pulses", 32'(pulses), 32'd300);
        check("sat_drop", 32'(bus_if.drop_cnt), 32'hFF);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/cmd_arb.md
CMD_ARB -- requirements
Module: cmd_arb

Interface
REQ-001 Parameter TIMEOUT_CYC, default 1024: cycles cmd_rdy may stay unacknowledged before the held command is dropped.
REQ-002 Parameter CNT_W, default 11: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYC.
REQ-003 clk  in  1  single system clock; all state updates on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 rdy_a  in  1  source A (BLE UART) holds a valid command.
REQ-006 cmd_a  in  8  source A command byte.
REQ-007 clr_a  out  1  one-cycle pulse consuming source A's command.
REQ-008 rdy_b  in  1  source B (debug UART) holds a valid command.
REQ-009 cmd_b  in  8  source B command byte.
REQ-010 clr_b  out  1  one-cycle pulse consuming source B's command.
REQ-011 cmd_rdy  out  1  command presented to the command processor.
REQ-012 cmd  out  8  presented command byte, from a register.
REQ-013 clr_cmd_rdy  in  1  command processor acknowledges the presented command.
REQ-014 src_b  out  1  0 = presented command came from A, 1 = from B.
REQ-015 timeout  out  1  one-cycle pulse when a presented command is dropped.
REQ-016 drop_cnt  out  8  saturating count of timeouts.

Function
REQ-017 The FSM SHALL have exactly two states: IDLE and PRESENT.
REQ-018 In IDLE with rdy_a or rdy_b high, the arbiter SHALL grant one source on that edge, latch its byte into cmd, set src_b, pulse the matching clr_x for exactly one cycle, and move to PRESENT.
REQ-019 Round-robin arbitration: if both rdy are high, grant the source not granted last; if only one is high, grant it.
REQ-020 The last-grant pointer SHALL update only on a grant.
REQ-021 clr_a and clr_b SHALL never be high in the same cycle.
REQ-022 In PRESENT, cmd_rdy SHALL be 1 and registered; cmd and src_b SHALL hold stable.
REQ-023 Latency: cmd_rdy goes high the cycle after the grant edge (one cycle after rdy is sampled).
REQ-024 In PRESENT with clr_cmd_rdy high, the FSM SHALL return to IDLE and cmd_rdy SHALL be 0 the next cycle.
REQ-025 There SHALL be a minimum of one IDLE cycle between presented commands.
REQ-026 The timeout counter SHALL clear on entry to PRESENT and increment each PRESENT cycle without clr_cmd_rdy.
REQ-027 When the counter reaches TIMEOUT_CYC-1 without clr_cmd_rdy, the block SHALL pulse timeout for one cycle, increment drop_cnt (saturating at 255), and return to IDLE.
REQ-028 If clr_cmd_rdy coincides with the timeout cycle, the command SHALL count as acknowledged: no timeout pulse and no drop_cnt change.
REQ-029 rdy_x changes while in PRESENT SHALL be ignored; sources wait and no clr_x is issued.
REQ-030 clr_cmd_rdy while in IDLE SHALL be ignored.
REQ-031 cmd SHALL retain its last presented value while in IDLE.

Reset
REQ-032 rst high SHALL asynchronously force the following, including mid-PRESENT:
  - state = IDLE
  - cmd_rdy = 0, cmd = 8'h00, src_b = 0
  - clr_a = 0, clr_b = 0, timeout = 0
  - drop_cnt = 0, timeout counter = 0
  - last-grant pointer = B, so A wins the first contention.
REQ-033 No clr_x or timeout pulse SHALL be issued while rst is high or in the cycle it deasserts.

Verification
REQ-034 After reset, rdy_a=1, cmd_a=8'h45, then clr_cmd_rdy pulsed 3 cycles after cmd_rdy rises -> clr_a pulses once, cmd_rdy=1 with cmd=8'h45 and src_b=0 for 3 cycles, then IDLE.
REQ-035 rdy_a=rdy_b=1 held, cmd_a=8'h41, cmd_b=8'h82, each presented command acked immediately -> grants alternate A,B,A,B starting with A, and clr_a/clr_b are never simultaneous.
REQ-036 rdy_b=1, cmd_b=8'h7F, no ack, TIMEOUT_CYC=16 -> cmd_rdy high exactly 16 cycles, timeout pulses once, drop_cnt=1.
REQ-037 Same as REQ-036 but clr_cmd_rdy arrives on cycle 16 -> no timeout pulse, drop_cnt=0.
REQ-038 rst asserted mid-PRESENT with drop_cnt=5 -> cmd_rdy=0, cmd=8'h00, drop_cnt=0 immediately; after release with both rdy high, A is granted first.
REQ-039 300 consecutive timeouts -> drop_cnt saturates at 8'hFF.
